// File: rtl/pcs_tx_ordered_set_if.sv
// GMII-side transmit inputs and encoder-side outputs of the 1000BASE-X PCS
// transmit ordered-set controller.
interface pcs_tx_ordered_set_if;
   logic       XMIT_DATA;
   logic       TX_EN;
   logic       TX_ER;
   logic [7:0] TXD;
   logic       TX_DISP;
   logic [7:0] TX_OCTET;
   logic       TX_IS_K;
   logic       TX_EVEN;
   logic       TRANSMITTING;

   modport master (
      output XMIT_DATA, TX_EN, TX_ER, TXD, TX_DISP,
      input  TX_OCTET, TX_IS_K, TX_EVEN, TRANSMITTING
   );

   modport slave (
      input  XMIT_DATA, TX_EN, TX_ER, TXD, TX_DISP,
      output TX_OCTET, TX_IS_K, TX_EVEN, TRANSMITTING
   );
endinterface

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set controller: picks idle/SOP/data/EOP code-groups
// for the 8b/10b encoder, keeping commas on even slots. Define CARRIER_EXT_EN for carrier extension.
module pcs_tx_ordered_set #(
   parameter int unsigned MIN_IDLE_PAIRS = 1,
   parameter int unsigned CNT_W          = 4
) (
   input logic                 CLK,
   input logic                 RESET,
   pcs_tx_ordered_set_if.slave bus
);

   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_IDLE_PAIRS);
   localparam logic [7:0] OCT_K28_5 = 8'hBC;
   localparam logic [7:0] OCT_S     = 8'hFB;
   localparam logic [7:0] OCT_T     = 8'hFD;
   localparam logic [7:0] OCT_R     = 8'hF7;
   localparam logic [7:0] OCT_V     = 8'hFE;
   localparam logic [7:0] OCT_D5_6  = 8'hC5;
   localparam logic [7:0] OCT_D16_2 = 8'h50;

   typedef enum logic [2:0] {
      ST_IDLE_K = 3'd0,
      ST_IDLE_D = 3'd1,
      ST_SOP    = 3'd2,
      ST_DATA   = 3'd3,
      ST_EPD2   = 3'd4,
      ST_EPD3   = 3'd5,
      ST_EXTEND = 3'd6
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [7:0]       r_octet;
   logic [7:0]       w_octet;
   logic             r_is_k;
   logic             w_is_k;
   logic             r_even;
   logic             r_trans;
   logic             w_trans;
   logic             w_slot_even;
   logic             w_data_ok;
`ifdef CARRIER_EXT_EN
   logic             w_ext_start;
   logic             w_ext_hold;
`endif

   // r_even holds the parity of the slot on the outputs; the slot being decided is the opposite one
   assign w_slot_even = ~r_even;
   assign w_data_ok   = bus.TX_EN & bus.XMIT_DATA;
   assign w_cnt_inc   = (r_cnt >= MIN_CNT) ? MIN_CNT : r_cnt + CNT_W'(1);
`ifdef CARRIER_EXT_EN
   assign w_ext_hold  = ~bus.TX_EN & bus.TX_ER;
   assign w_ext_start = w_ext_hold & (bus.TXD == 8'h0F);
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE_K;
         r_cnt   <= MIN_CNT;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE_K: w_state_nxt = ST_IDLE_D;
         ST_IDLE_D: begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_data_ok && (w_cnt_inc == MIN_CNT)) ? ST_SOP : ST_IDLE_K;
         end
         ST_SOP: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_data_ok) begin
               w_state_nxt = ST_DATA;
`ifdef CARRIER_EXT_EN
            end else if (w_ext_start) begin
               w_state_nxt = ST_EXTEND;
`endif
            end else begin
               w_state_nxt = ST_EPD2;
            end
         end
         ST_EPD2:   w_state_nxt = w_slot_even ? ST_EPD3 : ST_IDLE_K;
         ST_EPD3:   w_state_nxt = ST_IDLE_K;
`ifdef CARRIER_EXT_EN
         // leaving extension behaves as EPD2 in the same slot
         ST_EXTEND: begin
            if (w_ext_hold) w_state_nxt = ST_EXTEND;
            else            w_state_nxt = w_slot_even ? ST_EPD3 : ST_IDLE_K;
         end
`endif
         default:   w_state_nxt = ST_IDLE_K;
      endcase
   end

   always_comb begin
      w_octet = 8'h00;
      w_is_k  = 1'b0;
      w_trans = 1'b0;
      case (r_state)
         ST_IDLE_K: begin
            w_octet = OCT_K28_5;
            w_is_k  = 1'b1;
         end
         ST_IDLE_D: w_octet = bus.TX_DISP ? OCT_D5_6 : OCT_D16_2;
         ST_SOP: begin
            w_octet = OCT_S;
            w_is_k  = 1'b1;
            w_trans = 1'b1;
         end
         ST_DATA: begin
            w_trans = 1'b1;
            w_is_k  = 1'b1;
            if (w_data_ok) begin
               if (bus.TX_ER) begin
                  w_octet = OCT_V;
               end else begin
                  w_octet = bus.TXD;
                  w_is_k  = 1'b0;
               end
            end else if (!bus.TX_EN) begin
`ifdef CARRIER_EXT_EN
               w_octet = w_ext_start ? OCT_R : OCT_T;
`else
               w_octet = OCT_T;
`endif
            end else begin
               w_octet = OCT_V;
            end
         end
         ST_EPD2, ST_EPD3: begin
            w_octet = OCT_R;
            w_is_k  = 1'b1;
            w_trans = 1'b1;
         end
`ifdef CARRIER_EXT_EN
         ST_EXTEND: begin
            w_octet = (w_ext_hold && (bus.TXD != 8'h0F)) ? OCT_V : OCT_R;
            w_is_k  = 1'b1;
            w_trans = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // registered encoder-side outputs; parity simply toggles every cycle out of reset
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_octet <= 8'h00;
         r_is_k  <= 1'b0;
         r_even  <= 1'b0;
         r_trans <= 1'b0;
      end else begin
         r_octet <= w_octet;
         r_is_k  <= w_is_k;
         r_even  <= ~r_even;
         r_trans <= w_trans;
      end
   end

   assign bus.TX_OCTET     = r_octet;
   assign bus.TX_IS_K      = r_is_k;
   assign bus.TX_EVEN      = r_even;
   assign bus.TRANSMITTING = r_trans;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Directed bench for pcs_tx_ordered_set (MIN_IDLE_PAIRS=3): idle loop, frames, /T/ parity,
// error, XMIT_DATA drop, back-to-back gap, async reset and (with CARRIER_EXT_EN) extension.
module tb_pcs_tx_ordered_set;

   localparam int unsigned MIN_PAIRS = 3;

   logic CLK;
   logic RESET;
   int   n_chk;
   int   n_pass;

   pcs_tx_ordered_set_if u_if ();

   pcs_tx_ordered_set #(
      .MIN_IDLE_PAIRS (MIN_PAIRS),
      .CNT_W          (4)
   ) u_dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (u_if)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got oct=%h k=%b even=%b tx=%b, expected oct=%h k=%b even=%b tx=%b",
                    tag, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
   endtask

   function automatic logic [10:0] obs();
      return {u_if.TX_OCTET, u_if.TX_IS_K, u_if.TX_EVEN, u_if.TRANSMITTING};
   endfunction

   // drive one cycle of GMII inputs, then check the code-group emitted at that edge
   task automatic cyc(input string tag, input logic en, input logic er, input logic [7:0] d,
                      input logic [7:0] eo, input logic ek, input logic ev, input logic et);
      u_if.TX_EN = en;
      u_if.TX_ER = er;
      u_if.TXD   = d;
      @(posedge CLK);
      #1;
      chk(tag, obs(), {eo, ek, ev, et});
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      RESET  = 1'b1;
      u_if.XMIT_DATA = 1'b0;
      u_if.TX_EN     = 1'b0;
      u_if.TX_ER     = 1'b0;
      u_if.TXD       = 8'h00;
      u_if.TX_DISP   = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset", obs(), 11'h000);
      RESET = 1'b0;

      // idles only: TX_EN asserted but XMIT_DATA=0 must be ignored
      for (int k = 0; k < 20; k++) begin
         u_if.TX_DISP = k[1];
         if ((k % 2) == 0) cyc("idle_k", 1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0);
         else cyc("idle_d", 1'b1, 1'b0, 8'h55, k[1] ? 8'hC5 : 8'h50, 1'b0, 1'b0, 1'b0);
      end

      // frame A: even data count, /T/ on odd slot -> EPD3 needed
      u_if.XMIT_DATA = 1'b1;
      u_if.TX_DISP   = 1'b1;
      cyc("a_idle_k", 1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("a_idle_d", 1'b1, 1'b0, 8'h55, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("a_sop",    1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
      cyc("a_d0",     1'b1, 1'b0, 8'hD5, 8'hD5, 1'b0, 1'b0, 1'b1);
      cyc("a_d1",     1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
      cyc("a_d2",     1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
      cyc("a_d3",     1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b1, 1'b1);
      cyc("a_t",      1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1);
      // TX_EN re-asserted one cycle after /T/: gap must still be exactly 3 idle pairs
      cyc("a_epd2",   1'b1, 1'b0, 8'h55, 8'hF7, 1'b1, 1'b1, 1'b1);
      cyc("a_epd3",   1'b1, 1'b0, 8'h55, 8'hF7, 1'b1, 1'b0, 1'b1);
      cyc("gap_k1",   1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("gap_d1",   1'b1, 1'b0, 8'h55, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("gap_k2",   1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("gap_d2",   1'b1, 1'b0, 8'h55, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("gap_k3",   1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("gap_d3",   1'b1, 1'b0, 8'h55, 8'hC5, 1'b0, 1'b0, 1'b0);

      // frame B: one TX_ER octet, odd data count, /T/ on even slot -> no EPD3
      cyc("b_sop",    1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
      cyc("b_d0",     1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0, 1'b1);
      cyc("b_err",    1'b1, 1'b1, 8'hAA, 8'hFE, 1'b1, 1'b1, 1'b1);
      cyc("b_d2",     1'b1, 1'b0, 8'h22, 8'h22, 1'b0, 1'b0, 1'b1);
      cyc("b_t",      1'b0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b1, 1'b1);
      cyc("b_epd2",   1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
      cyc("b_idle_k", 1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);

      // frame C: TX_ER with TX_EN at the IDLE_D decision still starts with plain /S/
      u_if.TX_DISP = 1'b0;
      cyc("c_d1",     1'b1, 1'b1, 8'h99, 8'h50, 1'b0, 1'b0, 1'b0);
      cyc("c_k2",     1'b1, 1'b1, 8'h99, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("c_d2",     1'b1, 1'b1, 8'h99, 8'h50, 1'b0, 1'b0, 1'b0);
      cyc("c_k3",     1'b1, 1'b1, 8'h99, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("c_d3",     1'b1, 1'b1, 8'h99, 8'h50, 1'b0, 1'b0, 1'b0);
      cyc("c_sop",    1'b1, 1'b1, 8'h99, 8'hFB, 1'b1, 1'b1, 1'b1);
      cyc("c_d0",     1'b1, 1'b0, 8'h33, 8'h33, 1'b0, 1'b0, 1'b1);

      // asynchronous reset mid-frame, between clock edges
      #2;
      RESET = 1'b1;
      #1;
      chk("rst_async", obs(), 11'h000);
      @(posedge CLK);
      #1;
      chk("rst_hold", obs(), 11'h000);
      RESET = 1'b0;

      // frame D: counter back at MIN, XMIT_DATA dropped mid-frame -> /V/ then /R/
      u_if.TX_DISP = 1'b1;
      cyc("d_idle_k", 1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("d_idle_d", 1'b1, 1'b0, 8'h55, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("d_sop",    1'b1, 1'b0, 8'h55, 8'hFB, 1'b1, 1'b1, 1'b1);
      cyc("d_d0",     1'b1, 1'b0, 8'h66, 8'h66, 1'b0, 1'b0, 1'b1);
      u_if.XMIT_DATA = 1'b0;
      cyc("d_v",      1'b1, 1'b0, 8'h44, 8'hFE, 1'b1, 1'b1, 1'b1);
      cyc("d_epd2",   1'b1, 1'b0, 8'h44, 8'hF7, 1'b1, 1'b0, 1'b1);
      cyc("d_idle_k2", 1'b1, 1'b0, 8'h44, 8'hBC, 1'b1, 1'b1, 1'b0);
      u_if.XMIT_DATA = 1'b1;

`ifdef CARRIER_EXT_EN
      // frame E: five /R/ of extension replace /T/, then alignment /R/ and idle
      cyc("e_d1",     1'b1, 1'b0, 8'h99, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("e_k2",     1'b1, 1'b0, 8'h99, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("e_d2",     1'b1, 1'b0, 8'h99, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("e_k3",     1'b1, 1'b0, 8'h99, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("e_d3",     1'b1, 1'b0, 8'h99, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("e_sop",    1'b1, 1'b0, 8'h99, 8'hFB, 1'b1, 1'b1, 1'b1);
      cyc("e_d0",     1'b1, 1'b0, 8'h77, 8'h77, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++)
         cyc("e_ext", 1'b0, 1'b1, 8'h0F, 8'hF7, 1'b1, ((k % 2) == 0), 1'b1);
      cyc("e_align",  1'b0, 1'b0, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1);
      cyc("e_idle_k", 1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);
`else
      // without the extension feature TX_ER with TX_EN=0 is plain end of frame
      cyc("e_d1",     1'b1, 1'b0, 8'h99, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("e_k2",     1'b1, 1'b0, 8'h99, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("e_d2",     1'b1, 1'b0, 8'h99, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("e_k3",     1'b1, 1'b0, 8'h99, 8'hBC, 1'b1, 1'b1, 1'b0);
      cyc("e_d3",     1'b1, 1'b0, 8'h99, 8'hC5, 1'b0, 1'b0, 1'b0);
      cyc("e_sop",    1'b1, 1'b0, 8'h99, 8'hFB, 1'b1, 1'b1, 1'b1);
      cyc("e_d0",     1'b1, 1'b0, 8'h77, 8'h77, 1'b0, 1'b0, 1'b1);
      cyc("e_t",      1'b0, 1'b1, 8'h0F, 8'hFD, 1'b1, 1'b1, 1'b1);
      cyc("e_epd2",   1'b0, 1'b1, 8'h0F, 8'hF7, 1'b1, 1'b0, 1'b1);
      cyc("e_idle_k", 1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
